// File: rtl/input_debouncer_pkg.sv
// Shared processor constants for the board input debouncer.
// Widths of the key/switch buses and the default qualification time.
package input_debouncer_pkg;

  localparam int unsigned KEY_BITS                = 4;
  localparam int unsigned SW_BITS                 = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;

  // Counter width able to hold 0..cycles.
  function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
    return (cycles + 1 <= 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: synchronizer chain, qualification counter and debounced value.
// d_next_c exposes the value D takes on the coming edge so the parent can register edge pulses.
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic d_o,
  output logic d_next_c
);

  localparam int unsigned CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   d_q, d_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Count while S disagrees with D; any agreement restarts qualification.
  always_comb begin
    cnt_d = '0;
    d_d   = d_q;
    if (s != d_q) begin
      if (cnt_q == CNT_LIMIT) begin
        d_d = s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      d_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q  <= cnt_d;
      d_q    <= d_d;
    end
  end

  assign d_o      = d_q;
  assign d_next_c = d_d;

endmodule

// File: rtl/input_debouncer.sv
// Debounces the board push-buttons and slide switches for the processor.
// Keys are normalised to 1 = pressed before synchronizing; presses yield a one-cycle pulse.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_BITS-1:0] key_raw,
  input  logic [SW_BITS-1:0]  sw_raw,
  output logic [KEY_BITS-1:0] key_out,
  output logic [SW_BITS-1:0]  sw_out,
  output logic [KEY_BITS-1:0] key_press
);

  logic [KEY_BITS-1:0] key_norm;
  logic [KEY_BITS-1:0] key_next;
  logic [SW_BITS-1:0]  sw_next;
  logic [KEY_BITS-1:0] key_press_q, key_press_d;

  assign key_norm = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

  for (genvar i = 0; i < KEY_BITS; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (key_norm[i]),
      .d_o      (key_out[i]),
      .d_next_c (key_next[i])
    );
  end

  for (genvar i = 0; i < SW_BITS; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (sw_raw[i]),
      .d_o      (sw_out[i]),
      .d_next_c (sw_next[i])
    );
  end

  // Pulse is registered alongside the 0->1 update of key_out, so both are visible together.
  assign key_press_d = key_next & ~key_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_press_q <= '0;
    end else begin
      key_press_q <= key_press_d;
    end
  end

  assign key_press = key_press_q;

endmodule
